// File: rtl/uart_tx_feeder_if.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder_if : byte-producer / transmitter-side bundle for uart_tx_feeder (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_tx_feeder_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          transmit;
  logic [7:0]    data;
  logic          busy;

  modport master (
    output wr_en, wr_data,
    input  full, empty, count, overflow, transmit, data, busy
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, count, overflow, transmit, data, busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder : byte FIFO + fixed-slot pacer for a status-less 8N1 UART TX (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_feeder #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DEPTH        = 16,
  parameter int FRAME_BITS   = 14
) (
  input  logic            clk,
  input  logic            reset_n,
  uart_tx_feeder_if.slave bus
);
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int SLOT     = FRAME_BITS * CLKS_PER_BIT;
  localparam int HOLD_CYC = CLKS_PER_BIT + 2;
  localparam int GAP_CYC  = SLOT - 1 - HOLD_CYC;
  localparam int TW       = $clog2(SLOT);

  localparam logic [TW-1:0] C_HOLD_LD  = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] C_GAP_LD   = TW'(GAP_CYC - 1);
  localparam logic [CW-1:0] C_FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t        state_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [TW-1:0] tmr_q;
  logic          full_q;
  logic          empty_q;
  logic          overflow_q;
  logic          transmit_q;
  logic [7:0]    data_q;
  logic          busy_q;
  logic          pop_d;
  logic          push_d;

  // A pop in the same cycle frees a slot, so a write at full is still taken.
  always_comb begin
    pop_d   = (state_q == LOAD);
    push_d  = bus.wr_en && (!full_q || pop_d);
    count_d = count_q;
    if (push_d && !pop_d) begin
      count_d = count_q + CW'(1);
    end else if (pop_d && !push_d) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_d) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tmr_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      transmit_q <= 1'b0;
      data_q     <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      full_q     <= (count_d == C_FULL_CNT);
      empty_q    <= (count_d == '0);
      overflow_q <= bus.wr_en && !push_d;
      if (push_d) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end

      case (state_q)
        IDLE: begin
          if (!empty_q) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          data_q     <= mem_q[rd_ptr_q];
          rd_ptr_q   <= rd_ptr_q + AW'(1);
          transmit_q <= 1'b1;
          tmr_q      <= C_HOLD_LD;
          state_q    <= HOLD;
        end
        HOLD: begin
          if (tmr_q == '0) begin
            transmit_q <= 1'b0;
            tmr_q      <= C_GAP_LD;
            state_q    <= GAP;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        GAP: begin
          // Slot boundary: decide on the registered empty flag only.
          if (tmr_q == '0) begin
            if (!empty_q) begin
              state_q <= LOAD;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.transmit = transmit_q;
  assign bus.data     = data_q;
  assign bus.busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_feeder : scoreboard bench with a slot-timeline reference model (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_feeder;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int FB    = 14;
  localparam int SLOT  = FB * CPB;
  localparam int HOLD  = CPB + 2;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int SW    = CW + 13;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  uart_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_feeder #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH),
    .FRAME_BITS  (FB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model: byte queue plus slot start time; a slot is SLOT edges long
  int         cyc      = 0;
  int         m_S      = 0;
  bit         m_active = 1'b0;
  bit         m_ovf    = 1'b0;
  logic [7:0] m_data   = 8'h00;
  logic [7:0] m_fifo[$];
  logic [7:0] sb_q[$];
  int         m_cprev;
  bit         m_pop;
  bit         m_acc;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  function automatic int m_count();
    return m_fifo.size();
  endfunction

  function automatic bit m_tx();
    return m_active && (cyc >= m_S + 1) && (cyc <= m_S + HOLD);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_active = 1'b0;
        m_ovf    = 1'b0;
        m_data   = 8'h00;
        m_fifo.delete();
        sb_q.delete();
      end else begin
        cyc++;
        m_cprev = m_fifo.size();
        m_pop   = m_active && (cyc == m_S + 1);
        m_acc   = bus.wr_en && ((m_cprev < DEPTH) || m_pop);
        m_ovf   = bus.wr_en && !m_acc;
        if (m_pop) m_data = m_fifo.pop_front();
        if (m_acc) begin
          m_fifo.push_back(bus.wr_data);
          sb_q.push_back(bus.wr_data);
        end
        if (m_active && (cyc == m_S + SLOT)) begin
          if (m_cprev > 0) m_S = cyc;
          else m_active = 1'b0;
        end else if (!m_active && (m_cprev > 0)) begin
          m_active = 1'b1;
          m_S      = cyc;
        end
      end
    end
  end

  // Monitor: status every cycle; on each transmit rise pop and compare the byte
  logic [SW-1:0] st_act;
  logic [SW-1:0] st_exp;
  logic [7:0]    sb_want;
  bit            prev_tx = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        st_act = {bus.full, bus.empty, bus.count, bus.overflow, bus.transmit, bus.busy, bus.data};
        if (!reset_n)
          st_exp = {1'b0, 1'b1, CW'(0), 1'b0, 1'b0, 1'b0, 8'h00};
        else
          st_exp = {(m_count() == DEPTH), (m_count() == 0), CW'(m_count()), m_ovf, m_tx(), m_active, m_data};
        n_cmp++;
        if (st_act !== st_exp) begin
          n_bad++;
          $display("FAIL status cyc=%0d got{full,empty,count,ovf,tx,busy,data}=%h want=%h",
                   cyc, st_act, st_exp);
        end
        if (reset_n && bus.transmit && !prev_tx) begin
          n_cmp++;
          if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL byte_order cyc=%0d got=%h want=<none queued>", cyc, bus.data);
          end else begin
            sb_want = sb_q.pop_front();
            if (bus.data !== sb_want) begin
              n_bad++;
              $display("FAIL byte_order cyc=%0d got=%h want=%h", cyc, bus.data, sb_want);
            end
          end
        end
      end
      prev_tx = reset_n ? bus.transmit : 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic bit in_gap();
    return m_active && (cyc >= m_S + HOLD + 3) && (cyc + 1 < m_S + SLOT);
  endfunction

  function automatic bit in_load_full();
    return m_active && (cyc == m_S) && (m_count() == DEPTH);
  endfunction

  function automatic bit in_hold();
    return m_active && (cyc >= m_S + 1) && (cyc + 2 <= m_S + HOLD);
  endfunction

  function automatic bit drained();
    return !m_active && (m_count() == 0);
  endfunction

  int  p;
  int  k;

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    idle(2);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_transmit", 32'(bus.transmit), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    reset_n = 1'b1;
    idle(3);

    // Single byte: latency, hold length and slot length come from the monitor
    wr(8'hA5);
    idle(SLOT + 20);

    // Burst to full, then overflow while in GAP
    for (int i = 1; i <= 5; i++) wr(8'(i));
    chk("burst_full", 32'(bus.full), 1);
    for (k = 0; k < 400 && !in_gap(); k++) tick();
    chk("wait_gap", 32'(in_gap()), 1);
    wr(8'hFF);
    chk("ovf_pulse", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), DEPTH);
    tick();
    chk("ovf_one_cycle", 32'(bus.overflow), 0);

    // Write coincident with the LOAD pop while full
    for (k = 0; k < 400 && !in_load_full(); k++) tick();
    chk("wait_load_full", 32'(in_load_full()), 1);
    wr(8'h3C);
    chk("pop_wr_no_ovf", 32'(bus.overflow), 0);
    chk("pop_wr_count", 32'(bus.count), DEPTH);

    for (k = 0; k < 2000 && !drained(); k++) tick();
    chk("drain1", 32'(drained()), 1);
    idle(3);

    // Paced bytes so pointers wrap
    for (int i = 0; i < 6; i++) begin
      wr(8'($urandom));
      idle(SLOT + int'($urandom_range(0, 20)));
    end
    chk("paced_empty", 32'(bus.empty), 1);

    // Random traffic with varying density
    for (int b = 0; b < 6; b++) begin
      p = int'($urandom_range(3, 90));
      for (int c = 0; c < 300; c++) begin
        bus.wr_en   = ($urandom_range(0, 99) < p);
        bus.wr_data = 8'($urandom);
        tick();
      end
    end
    bus.wr_en = 1'b0;

    // Reset during HOLD
    wr(8'h5A);
    wr(8'hC3);
    for (k = 0; k < 1000 && !in_hold(); k++) tick();
    chk("wait_hold", 32'(in_hold()), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_transmit", 32'(bus.transmit), 0);
    chk("rst_mid_count", 32'(bus.count), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(SLOT + 30);
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_transmit", 32'(bus.transmit), 0);

    // Final traffic and drain: every accepted byte must have been sent
    wr(8'h11);
    wr(8'h22);
    for (k = 0; k < 2000 && !drained(); k++) tick();
    chk("drain2", 32'(drained()), 1);
    idle(5);
    chk("scoreboard_empty", 32'(sb_q.size()), 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
